vector_packer: RTL and testbench

Upstream feeder for `conversion`: collects a stream of DATA_W-bit elements over a valid/ready handshake and packs N of them into one N×DATA_W-bit vector. Each vector is presented on `out_vector` with a valid/ready handshake, and its width matches `conversion`'s `Vector` input (16×8 = 128 bits by default). An early `in_last` closes a short vector with zero padding. The block holds one vector being assembled and one vector being offered, so the input can keep streaming while the consumer stalls.

---
 rtl/vector_packer_if.sv | 27 ++
 rtl/vector_packer.sv | 96 +++++++++
 tb/tb_vector_packer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vector_packer_if.sv
// Handshake bundle between the element stream, vector_packer and the vector consumer.
// The packer connects through the master modport, the environment through slave.
interface vector_packer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N      = 16
);
    localparam int unsigned LenW = $clog2(N) + 1;

    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [N*DATA_W-1:0] out_vector;
    logic [LenW-1:0]     out_len;
    logic                out_valid;
    logic                out_ready;

    modport master (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_vector, out_len, out_valid
    );

    modport slave (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_vector, out_len, out_valid
    );
endinterface

// File: rtl/vector_packer.sv
// Packs a stream of DATA_W-bit elements into N-lane vectors, zero-padding vectors closed
// early by in_last. One vector is assembled while a second is offered downstream.
module vector_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N      = 16
) (
    input logic               clk,
    input logic               rst,
    vector_packer_if.master   bus
);
    localparam int unsigned CntW = $clog2(N);
    localparam int unsigned LenW = CntW + 1;

    typedef logic [N-1:0][DATA_W-1:0] vec_t;

    vec_t            asm_q, asm_d, out_vec_q, out_vec_d, asm_wr;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [LenW-1:0] asm_len_q, asm_len_d, out_len_q, out_len_d, cur_len;
    logic            asm_full_q, asm_full_d;
    logic            out_valid_q, out_valid_d;
    logic            accept, xfer, slot_free, close;

    assign bus.in_ready   = !asm_full_q && !rst;
    assign bus.out_vector = out_vec_q;
    assign bus.out_len    = out_len_q;
    assign bus.out_valid  = out_valid_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign xfer      = out_valid_q && bus.out_ready;
    assign slot_free = !out_valid_q || bus.out_ready;
    assign close     = accept && (bus.in_last || cnt_q == CntW'(N - 1));
    assign cur_len   = LenW'(cnt_q) + LenW'(1);

    always_comb begin
        asm_wr        = asm_q;
        asm_wr[cnt_q] = bus.in_data;
        asm_d         = asm_q;
        cnt_d         = cnt_q;
        asm_len_d     = asm_len_q;
        asm_full_d    = asm_full_q;
        out_vec_d     = out_vec_q;
        out_len_d     = out_len_q;
        out_valid_d   = out_valid_q;

        if (asm_full_q) begin
            // in_ready is low here, so the only event is the held vector moving out.
            if (xfer) begin
                out_vec_d   = asm_q;
                out_len_d   = asm_len_q;
                out_valid_d = 1'b1;
                asm_d       = '0;
                asm_full_d  = 1'b0;
            end
        end else if (close) begin
            cnt_d = '0;
            if (slot_free) begin
                out_vec_d   = asm_wr;
                out_len_d   = cur_len;
                out_valid_d = 1'b1;
                asm_d       = '0;
            end else begin
                asm_d      = asm_wr;
                asm_len_d  = cur_len;
                asm_full_d = 1'b1;
            end
        end else begin
            if (accept) begin
                asm_d = asm_wr;
                cnt_d = cnt_q + CntW'(1);
            end
            if (xfer) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            asm_len_q   <= '0;
            asm_full_q  <= 1'b0;
            out_vec_q   <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            asm_len_q   <= asm_len_d;
            asm_full_q  <= asm_full_d;
            out_vec_q   <= out_vec_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_vector_packer.sv
// Bench for vector_packer: directed scenarios plus random traffic, checked every cycle
// against a queue-of-vectors reference model.
module tb_vector_packer;
    localparam int unsigned DW = 8;
    localparam int unsigned NE = 16;
    localparam int unsigned VW = DW * NE;
    localparam int unsigned LW = $clog2(NE) + 1;

    typedef struct packed {
        logic [VW-1:0] vec;
        logic [LW-1:0] len;
    } vec_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_packer_if #(.DATA_W(DW), .N(NE)) bus ();

    vector_packer #(.DATA_W(DW), .N(NE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: closed vectors awaiting transfer, plus the partial element list.
    vec_s          exp_q[$];
    logic [DW-1:0] part[$];
    int            m_acc = 0;
    bit            rst_seen = 1'b0;
    bit            m_rdy, m_acc_now;

    function automatic vec_s pack_part();
        vec_s r;
        r.vec = '0;
        foreach (part[i]) r.vec[i*DW +: DW] = part[i];
        r.len = LW'(part.size());
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            part.delete();
            rst_seen = 1'b1;
        end else begin
            rst_seen  = 1'b0;
            // Two pending vectors means one offered and one parked: the input stalls.
            m_rdy     = exp_q.size() < 2;
            m_acc_now = bus.in_valid && m_rdy;
            if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
            if (m_acc_now) begin
                m_acc++;
                part.push_back(bus.in_data);
                if (bus.in_last || part.size() == NE) begin
                    exp_q.push_back(pack_part());
                    part.delete();
                end
            end
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then step past the edge.
    task automatic cycle(input logic [DW-1:0] d, input logic v, input logic l, input logic r,
                         input logic rs);
        bus.in_data   = d;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = r;
        rst           = rs;
        #1;
        check("in_ready", VW'(bus.in_ready), VW'(!rs && exp_q.size() < 2));
        check("out_valid", VW'(bus.out_valid), VW'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("out_vector", bus.out_vector, exp_q[0].vec);
            check("out_len", VW'(bus.out_len), VW'(exp_q[0].len));
        end
        if (rst_seen) begin
            check("rst_vector", bus.out_vector, '0);
            check("rst_len", VW'(bus.out_len), '0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int base;
        int guard;
        int k;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full vector 0x01..0x10
        for (int i = 0; i < 16; i++) cycle(8'(i + 1), 1'b1, 1'b0, 1'b1, 1'b0);
        check("full_vec", bus.out_vector, 128'h100F0E0D0C0B0A090807060504030201);
        check("full_len", VW'(bus.out_len), VW'(16));
        check("full_valid", VW'(bus.out_valid), VW'(1));
        drain(1);

        // Downstream all-0x01 pattern
        for (int i = 0; i < 16; i++) cycle(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ones_vec", bus.out_vector, 128'h01010101010101010101010101010101);
        drain(1);

        // Short vector then a full one, no stale lanes
        cycle(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(8'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
        check("short_vec", bus.out_vector, 128'h00000000000000000000000000CCBBAA);
        check("short_len", VW'(bus.out_len), VW'(3));
        cycle(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ff_vec", bus.out_vector, {16{8'hFF}});
        check("ff_len", VW'(bus.out_len), VW'(16));
        drain(1);

        // Back-pressure: 40 elements offered, out_ready low for the first 40 cycles
        base  = m_acc;
        guard = 0;
        while (m_acc - base < 40 && guard < 200) begin
            k = m_acc - base;
            cycle(8'(k + 1), 1'b1, k == 39, guard >= 40, 1'b0);
            guard++;
        end
        check("bp_done", VW'(m_acc - base), VW'(40));
        drain(4);

        // Reset mid-fill
        for (int i = 0; i < 5; i++) cycle(8'(8'h50 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(8'(8'h60 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        drain(3);

        // Close of vector 2 coincides with transfer of vector 1
        for (int i = 0; i < 16; i++) cycle(8'(8'h20 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(8'(8'h40 + i), 1'b1, 1'b0, i == 15, 1'b0);
        check("sim_vec", bus.out_vector, 128'h4F4E4D4C4B4A49484746454443424140);
        drain(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(8'($urandom), $urandom_range(3) != 0, $urandom_range(7) == 0,
                  $urandom_range(1) == 1, $urandom_range(299) == 0);
        end
        drain(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
